// File: rtl/switch_mcu_imem_ahb_slave.sv
// AHB-Lite instruction memory slave with loader port, wait states and two-cycle ERROR response.
// Optional SWITCH_MCU_IMEM_WRITE_EN enables byte/half/word AHB writes; otherwise all writes are illegal.
module switch_mcu_imem_ahb_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                           in_clk,
  input  logic                           in_rst,
  input  logic                           in_hsel,
  input  logic [31:0]                    in_haddr,
  input  logic [1:0]                     in_htrans,
  input  logic                           in_hwrite,
  input  logic [3:0]                     in_hsize,
  input  logic [2:0]                     in_hburst,
  input  logic [3:0]                     in_hport,
  input  logic                           in_hmastlock,
  input  logic [31:0]                    in_hwdata,
  output logic                           out_hready,
  output logic                           out_hresp,
  output logic [31:0]                    out_hrdata,
  input  logic                           in_load_valid,
  input  logic [$clog2(DEPTH_WORDS)-1:0] in_load_addr,
  input  logic [31:0]                    in_load_data,
  input  logic                           in_load_last,
  output logic                           out_init_done
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          hready_q, hready_d;
  logic          hresp_q, hresp_d;
  logic [31:0]   hrdata_q, hrdata_d;
  logic          init_done_q, init_done_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          wr_pend_q, wr_pend_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [32:0]   off_c;
  logic          in_range_c, misalign_c, wr_ok_c, legal_c, capture_c;
  logic          load_c, commit_c;
  logic [AW-1:0] cap_idx_c, rd_idx_c;
  logic [3:0]    strb_c;
  logic [31:0]   merged_c, rd_word_c;
  logic          unused_c;

  assign unused_c = ^{in_hburst, in_hport, in_hmastlock};

  // Address decode: 33-bit offset so addresses below BASE_ADDR also fall out of range.
  assign off_c      = {1'b0, in_haddr} - {1'b0, BASE_ADDR};
  assign in_range_c = off_c < SPAN;
  assign cap_idx_c  = off_c[AW+1:2];
  assign misalign_c = ((in_hsize == 4'd1) && in_haddr[0]) ||
                      ((in_hsize == 4'd2) && (in_haddr[1:0] != 2'b00));
`ifdef SWITCH_MCU_IMEM_WRITE_EN
  assign wr_ok_c  = 1'b1;
  assign commit_c = wr_pend_q;
`else
  assign wr_ok_c  = !in_hwrite;
  assign commit_c = 1'b0;
`endif
  assign legal_c   = init_done_q && in_range_c && !misalign_c && (in_hsize <= 4'd2) && wr_ok_c;
  assign capture_c = (state_q == ST_IDLE) && hready_q && in_hsel && in_htrans[1];
  assign load_c    = in_load_valid && !init_done_q;

  // Byte-lane merge of a pending write; also forwarded to a read of the same word.
  always_comb begin
    strb_c = 4'b0000;
    case (size_q)
      2'd0:    strb_c = 4'b0001 << lane_q;
      2'd1:    strb_c = lane_q[1] ? 4'b1100 : 4'b0011;
      default: strb_c = 4'b1111;
    endcase
    merged_c = mem_q[idx_q];
    for (int b = 0; b < 4; b++) begin
      if (strb_c[b]) merged_c[8*b +: 8] = in_hwdata[8*b +: 8];
    end
    rd_idx_c  = (state_q == ST_IDLE) ? cap_idx_c : idx_q;
    rd_word_c = (commit_c && (rd_idx_c == idx_q)) ? merged_c : mem_q[rd_idx_c];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hready_d    = hready_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    size_d      = size_q;
    write_d     = write_q;
    wr_pend_d   = 1'b0;
    init_done_d = init_done_q || (load_c && in_load_last);
    case (state_q)
      ST_IDLE: begin
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        if (capture_c) begin
          idx_d   = cap_idx_c;
          lane_d  = in_haddr[1:0];
          size_d  = in_hsize[1:0];
          write_d = in_hwrite;
          if (!legal_c) begin
            state_d  = ST_ERR1;
            hready_d = 1'b0;
            hresp_d  = 1'b1;
          end else if (WS == 4'd0) begin
            wr_pend_d = in_hwrite;
            if (!in_hwrite) hrdata_d = rd_word_c;
          end else begin
            state_d  = ST_WAIT;
            cnt_d    = WS;
            hready_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = ST_IDLE;
          hready_d  = 1'b1;
          wr_pend_d = write_q;
          if (!write_q) hrdata_d = rd_word_c;
        end
      end
      ST_ERR1: begin
        state_d  = ST_ERR2;
        hready_d = 1'b1;
        hresp_d  = 1'b1;
      end
      default: begin
        state_d  = ST_IDLE;
        hready_d = 1'b1;
        hresp_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      hready_q    <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'd0;
      init_done_q <= 1'b0;
      idx_q       <= '0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      write_q     <= 1'b0;
      wr_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hready_q    <= hready_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      init_done_q <= init_done_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      write_q     <= write_d;
      wr_pend_q   <= wr_pend_d;
    end
  end

  // Image storage is intentionally not reset; loader and AHB writes never overlap in time.
  always_ff @(posedge in_clk) begin
    if (load_c)   mem_q[in_load_addr] <= in_load_data;
    if (commit_c) mem_q[idx_q]        <= merged_c;
  end

  assign out_hready    = hready_q;
  assign out_hresp     = hresp_q;
  assign out_hrdata    = hrdata_q;
  assign out_init_done = init_done_q;

endmodule

// File: tb/tb_switch_mcu_imem_ahb_slave.sv
// Directed scoreboard bench: one instance with 0 wait states, one with 1, sharing bus and loader.
module tb_switch_mcu_imem_ahb_slave;

`ifdef SWITCH_MCU_IMEM_WRITE_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [3:0]  hsize;
  logic [31:0] hwdata;
  logic        load_valid;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        load_last;
  logic        rdy0, resp0, done0, rdy1, resp1, done1;
  logic [31:0] rdata0, rdata1;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic        er;
    logic        chk;
    logic [31:0] d;
    string       tag;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model [2][4];

  always #5 clk = ~clk;

  switch_mcu_imem_ahb_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u0 (
    .in_clk(clk), .in_rst(rst), .in_hsel(hsel0), .in_haddr(haddr), .in_htrans(htrans),
    .in_hwrite(hwrite), .in_hsize(hsize), .in_hburst(3'd0), .in_hport(4'd0),
    .in_hmastlock(1'b0), .in_hwdata(hwdata), .out_hready(rdy0), .out_hresp(resp0),
    .out_hrdata(rdata0), .in_load_valid(load_valid), .in_load_addr(load_addr),
    .in_load_data(load_data), .in_load_last(load_last), .out_init_done(done0));

  switch_mcu_imem_ahb_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u1 (
    .in_clk(clk), .in_rst(rst), .in_hsel(hsel1), .in_haddr(haddr), .in_htrans(htrans),
    .in_hwrite(hwrite), .in_hsize(hsize), .in_hburst(3'd0), .in_hport(4'd0),
    .in_hmastlock(1'b0), .in_hwdata(hwdata), .out_hready(rdy1), .out_hresp(resp1),
    .out_hrdata(rdata1), .in_load_valid(load_valid), .in_load_addr(load_addr),
    .in_load_data(load_data), .in_load_last(load_last), .out_init_done(done1));

  function automatic logic rdy(input int s);
    return (s == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic resp(input int s);
    return (s == 0) ? resp0 : resp1;
  endfunction

  function automatic logic [31:0] rdata(input int s);
    return (s == 0) ? rdata0 : rdata1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int s, input logic [31:0] a, input logic [3:0] sz,
                             input logic [31:0] wd);
    logic [31:0] w;
    logic        en;
    w = model[s][a[3:2]];
    for (int b = 0; b < 4; b++) begin
      if (sz == 4'd0)      en = (int'(a[1:0]) == b);
      else if (sz == 4'd1) en = (int'(a[1]) == b / 2);
      else                 en = 1'b1;
      if (en) w[8*b +: 8] = wd[8*b +: 8];
    end
    model[s][a[3:2]] = w;
  endtask

  task automatic load_word(input int i, input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_addr  = 10'(i);
    load_data  = d;
    load_last  = last;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Single non-pipelined transfer; called and returns on a falling edge.
  task automatic xfer(input int s, input logic [31:0] a, input logic w, input logic [3:0] sz,
                      input logic [31:0] wd, input logic er, input string tag);
    exp_t e;
    int   waits;
    e.er  = er;
    e.chk = !w && !er;
    e.d   = model[s][a[3:2]];
    e.tag = tag;
    sb.push_back(e);
    hsel0 = (s == 0); hsel1 = (s == 1);
    haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
    @(negedge clk);
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd;
    waits = 0;
    while (rdy(s) !== 1'b1 && waits < 20) begin
      check({tag, "_wait_resp"}, 32'(resp(s)), 32'(er));
      waits++;
      @(negedge clk);
    end
    check({tag, "_waits"}, 32'(waits), er ? 32'd1 : ((s == 0) ? 32'd0 : 32'd1));
    e = sb.pop_front();
    check({e.tag, "_resp"}, 32'(resp(s)), 32'(e.er));
    if (e.chk) check({e.tag, "_data"}, rdata(s), e.d);
    if (w && !er) model_write(s, a, sz, wd);
    @(negedge clk);
    hwdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b0; hsel0 = 1'b0; hsel1 = 1'b0; haddr = 32'd0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 4'd2; hwdata = 32'd0;
    load_valid = 1'b0; load_addr = 10'd0; load_data = 32'd0; load_last = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) model[s][i] = 32'h1111_1111 * 32'(i + 1);

    @(negedge clk); @(negedge clk);
    check("rst_hready1", 32'(rdy1), 32'd1);
    check("rst_hresp1", 32'(resp1), 32'd0);
    check("rst_hrdata1", rdata1, 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_hready0", 32'(rdy0), 32'd1);
    check("rst_done0", 32'(done0), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) load_word(i, model[0][i], 1'b0);
    xfer(1, 32'h0, 1'b0, 4'd2, 32'd0, 1'b1, "fetch_before_done");
    check("done_before_last", 32'(done1), 32'd0);
    load_word(3, model[0][3], 1'b1);
    check("done_after_last1", 32'(done1), 32'd1);
    check("done_after_last0", 32'(done0), 32'd1);
    load_word(0, 32'hDEAD_BEEF, 1'b0);

    // IDLE and BUSY (with write flag set) give zero-wait OKAY and leave memory alone.
    hsel1 = 1'b1; haddr = 32'h8; htrans = 2'b00; hwrite = 1'b1; hsize = 4'd2;
    @(negedge clk);
    hwdata = 32'hFFFF_FFFF;
    check("idle_hready", 32'(rdy1), 32'd1);
    check("idle_hresp", 32'(resp1), 32'd0);
    htrans = 2'b01;
    @(negedge clk);
    check("busy_hready", 32'(rdy1), 32'd1);
    check("busy_hresp", 32'(resp1), 32'd0);
    hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'd0;
    @(negedge clk);

    xfer(1, 32'h8, 1'b0, 4'd2, 32'd0, 1'b0, "ws1_rd8");
    xfer(0, 32'h0, 1'b0, 4'd2, 32'd0, 1'b0, "ldr_ignored_rd0");

    // Pipelined back-to-back reads with zero wait states.
    e.er = 1'b0; e.chk = 1'b1; e.d = model[0][0]; e.tag = "b2b_rd0"; sb.push_back(e);
    hsel0 = 1'b1; haddr = 32'h0; htrans = 2'b10; hwrite = 1'b0; hsize = 4'd2;
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, "_hready"}, 32'(rdy0), 32'd1);
    check({e.tag, "_data"}, rdata0, e.d);
    e.er = 1'b0; e.chk = 1'b1; e.d = model[0][1]; e.tag = "b2b_rd4"; sb.push_back(e);
    haddr = 32'h4;
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, "_hready"}, 32'(rdy0), 32'd1);
    check({e.tag, "_hresp"}, 32'(resp0), 32'd0);
    check({e.tag, "_data"}, rdata0, e.d);
    hsel0 = 1'b0; htrans = 2'b00;
    @(negedge clk);

    xfer(1, 32'h2, 1'b0, 4'd2, 32'd0, 1'b1, "misalign_word");
    xfer(1, 32'h1000, 1'b0, 4'd2, 32'd0, 1'b1, "out_of_range");
    xfer(1, 32'hC, 1'b0, 4'd2, 32'd0, 1'b0, "after_err_rdC");
    xfer(0, 32'h0, 1'b0, 4'd3, 32'd0, 1'b1, "bad_hsize");
    xfer(0, 32'h1, 1'b0, 4'd1, 32'd0, 1'b1, "misalign_half");
    xfer(0, 32'h4, 1'b0, 4'd2, 32'd0, 1'b0, "after_err_rd4");

    xfer(1, 32'h5, 1'b1, 4'd0, 32'hFFFF_ABFF, !WEN, "wr_byte5");
    xfer(1, 32'h4, 1'b0, 4'd2, 32'd0, 1'b0, "rd4_after_wr");
    xfer(0, 32'h2, 1'b1, 4'd1, 32'hBEEF_0000, !WEN, "wr_half2");
    xfer(0, 32'h0, 1'b0, 4'd2, 32'd0, 1'b0, "rd0_after_wr");

    // Reset during a pending word write to 0x4 drops it.
    hsel1 = 1'b1; haddr = 32'h4; htrans = 2'b10; hwrite = 1'b1; hsize = 4'd2;
    @(negedge clk);
    hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hFFFF_FFFF;
    check("mid_hready_low", 32'(rdy1), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_hready", 32'(rdy1), 32'd1);
    check("mid_rst_hresp", 32'(resp1), 32'd0);
    check("mid_rst_done", 32'(done1), 32'd0);
    @(negedge clk);
    rst = 1'b1; hwdata = 32'd0;
    @(negedge clk);
    load_word(3, model[1][3], 1'b1);
    check("reload_done", 32'(done1), 32'd1);
    xfer(1, 32'h4, 1'b0, 4'd2, 32'd0, 1'b0, "rd4_after_rst");
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
